stream_chunk_sum: RTL

- Downstream consumer of a `map_add1`-style element stream (valid/ready, one `intN` word per beat).
- Accumulates CHUNK consecutive accepted elements, or fewer when terminated early by `in_last`, into one sum.
- Emits each sum with its element count on a registered valid/ready output stream.
- Sits between a per-element map stage and the sink that consumes per-chunk results.

---
 rtl/stream_chunk_sum_pkg.sv | 19 +
 rtl/stream_chunk_sum_if.sv | 32 +++
 rtl/stream_chunk_sum_add.sv | 39 +++
 rtl/stream_chunk_sum.sv | 123 ++++++++++++
 4 files changed

// File: rtl/stream_chunk_sum_pkg.sv
// Shared definitions for the stream_chunk_sum block: FSM state encoding,
// the default element width and the element-count width helper.
// Optional feature macro: STREAM_CHUNK_SUM_SAT_EN (saturating sums).
package stream_chunk_sum_pkg;

    // Element width of the upstream map stage's intN word
    localparam int INTN_W = 8;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Bits needed to count 0..chunk elements
    function automatic int len_w(input int chunk);
        return $clog2(chunk + 1);
    endfunction

endpackage

// File: rtl/stream_chunk_sum_if.sv
// Element input stream and chunk-result output stream of stream_chunk_sum.
// The slave modport is the chunk-sum block; the master modport is the
// surrounding logic that feeds elements and consumes results.
interface stream_chunk_sum_if
    import stream_chunk_sum_pkg::*;
#(
    parameter int IN_W  = INTN_W,
    parameter int OUT_W = 16,
    parameter int LEN_W = len_w(4)
) ();

    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic [LEN_W-1:0] out_len;
    logic             out_sat;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_len, out_sat, out_valid
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_len, out_sat, out_valid
    );

endinterface

// File: rtl/stream_chunk_sum_add.sv
// Combinational accumulator adder: acc + zero-extended element.
// Default build wraps modulo 2^OUT_W. With STREAM_CHUNK_SUM_SAT_EN the sum
// clamps at 2^OUT_W-1 and the ovf output reports the clamp.
module stream_chunk_sum_add
    import stream_chunk_sum_pkg::*;
#(
    parameter int IN_W  = INTN_W,
    parameter int OUT_W = 16
) (
    input  logic [OUT_W-1:0] acc,
    input  logic [IN_W-1:0]  elem,
    output logic [OUT_W-1:0] sum
`ifdef STREAM_CHUNK_SUM_SAT_EN
    ,
    output logic             ovf
`endif
);

`ifdef STREAM_CHUNK_SUM_SAT_EN
    logic [OUT_W:0] wide;

    function automatic logic [OUT_W-1:0] sat_clamp(input logic [OUT_W:0] w);
        return w[OUT_W] ? {OUT_W{1'b1}} : w[OUT_W-1:0];
    endfunction

    // One extra carry bit detects overflow; the clamp replaces the sum
    always_comb begin
        wide = {1'b0, acc} + (OUT_W + 1)'(elem);
        ovf  = wide[OUT_W];
        sum  = sat_clamp(wide);
    end
`else
    // Plain modulo-2^OUT_W addition
    always_comb begin
        sum = acc + OUT_W'(elem);
    end
`endif

endmodule

// File: rtl/stream_chunk_sum.sv
// Chunk accumulator for a valid/ready element stream. Sums CHUNK accepted
// elements (or fewer, closed early by in_last) and presents each sum with its
// element count on a registered valid/ready result stream. A result held in
// HOLD can be consumed in the same cycle the next chunk's first element
// arrives, so throughput is one element per cycle while out_ready is high.
// Optional feature macro: STREAM_CHUNK_SUM_SAT_EN (saturating sums + out_sat).
module stream_chunk_sum
    import stream_chunk_sum_pkg::*;
#(
    parameter int IN_W  = INTN_W,
    parameter int OUT_W = 16,
    parameter int CHUNK = 4,
    parameter int LEN_W = len_w(CHUNK)
) (
    input  logic              clk,
    input  logic              nrst,
    stream_chunk_sum_if.slave bus
);

    state_t           state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d, acc_base;
    logic [OUT_W-1:0] sum;
    logic [OUT_W-1:0] data_q, data_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, cnt_base;
    logic [LEN_W-1:0] len_q, len_d;
    logic             in_xfer, out_xfer, close;

    assign bus.in_ready  = (state_q == ST_ACC) ? 1'b1 : bus.out_ready;
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_data  = data_q;
    assign bus.out_len   = len_q;

    assign in_xfer  = bus.in_valid & bus.in_ready;
    assign out_xfer = bus.out_valid & bus.out_ready;

    // An element accepted in HOLD starts a fresh chunk, so it adds onto zero
    assign acc_base = (state_q == ST_ACC) ? acc_q : '0;
    assign cnt_base = (state_q == ST_ACC) ? cnt_q : '0;
    assign close    = (cnt_base == LEN_W'(CHUNK - 1)) || bus.in_last;

`ifdef STREAM_CHUNK_SUM_SAT_EN
    logic ovf, flag_q, flag_d, flag_base, sat_q, sat_d;

    assign flag_base   = (state_q == ST_ACC) ? flag_q : 1'b0;
    assign bus.out_sat = sat_q;

    stream_chunk_sum_add #(.IN_W(IN_W), .OUT_W(OUT_W)) u_add (
        .acc  (acc_base),
        .elem (bus.in_data),
        .sum  (sum),
        .ovf  (ovf)
    );
`else
    assign bus.out_sat = 1'b0;

    stream_chunk_sum_add #(.IN_W(IN_W), .OUT_W(OUT_W)) u_add (
        .acc  (acc_base),
        .elem (bus.in_data),
        .sum  (sum)
    );
`endif

    // Next state: close or extend the chunk on an accepted element, else drain
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        len_d   = len_q;
`ifdef STREAM_CHUNK_SUM_SAT_EN
        flag_d  = flag_q;
        sat_d   = sat_q;
`endif
        if (in_xfer) begin
            if (close) begin
                data_d  = sum;
                len_d   = cnt_base + LEN_W'(1);
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ST_HOLD;
`ifdef STREAM_CHUNK_SUM_SAT_EN
                sat_d   = flag_base | ovf;
                flag_d  = 1'b0;
`endif
            end else begin
                acc_d   = sum;
                cnt_d   = cnt_base + LEN_W'(1);
                state_d = ST_ACC;
`ifdef STREAM_CHUNK_SUM_SAT_EN
                flag_d  = flag_base | ovf;
`endif
            end
        end else if (out_xfer) begin
            state_d = ST_ACC;
        end
    end

    // State, accumulator and result registers; reset drops any partial chunk
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            len_q   <= '0;
`ifdef STREAM_CHUNK_SUM_SAT_EN
            flag_q  <= 1'b0;
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            len_q   <= len_d;
`ifdef STREAM_CHUNK_SUM_SAT_EN
            flag_q  <= flag_d;
            sat_q   <= sat_d;
`endif
        end
    end

endmodule
